// File: rtl/piton_vortex_pkg.sv
// -----------------------------------------------------------------------------
// piton_vortex_pkg
// Shared definitions for the Vortex AXI memory responder slice:
//   - AXI response encodings returned on the B and R channels
//   - write and read engine state enumerations
//   - word geometry for the default 512-bit x 1024-word configuration
// No ports (package).
// -----------------------------------------------------------------------------
package piton_vortex_pkg;

    // AXI response codes (EXOKAY is never produced by this responder)
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Default geometry; parameterised instances derive their own values
    localparam int WORD_BYTES = 512 / 8;
    localparam int IDX_WIDTH  = $clog2(1024);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/vortex_mem_array.sv
// -----------------------------------------------------------------------------
// vortex_mem_array
// Single-write / single-read word array with per-byte write enables and a
// registered read port. Contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   commit a write this cycle
//   wr_idx   in   word index written
//   wr_data  in   write word
//   wr_strb  in   byte enables for the write word
//   rd_en    in   load the read register this cycle
//   rd_idx   in   word index read
//   rd_data  out  registered read word (updates only when rd_en was high)
// -----------------------------------------------------------------------------
module vortex_mem_array
    import piton_vortex_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024,
    parameter int INDEX_BITS = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [INDEX_BITS-1:0]   wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [INDEX_BITS-1:0]   rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes plus a registered read. Both use non-blocking
    // assignments, so a read of the index being written in the same cycle
    // returns the old word and the write lands at the edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/vortex_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// vortex_axi_mem_responder
// AXI4 slave backing the Vortex memory master port with a local word array.
// Independent write and read engines, one outstanding INCR burst each,
// full-width beats, low address bits ignored.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   s_axi_aw* (valid/ready/addr/id/len)        write address channel
//   s_axi_w*  (valid/ready/data/strb/last)     write data channel
//   s_axi_b*  (valid/ready/id/resp)            write response channel
//   s_axi_ar* (valid/ready/addr/id/len)        read address channel
//   s_axi_r*  (valid/ready/data/last/id/resp)  read data channel
// -----------------------------------------------------------------------------
module vortex_axi_mem_responder
    import piton_vortex_pkg::*;
#(
    parameter int                      ID_WIDTH   = 32,
    parameter int                      ADDR_WIDTH = 64,
    parameter int                      DATA_WIDTH = 512,
    parameter int                      MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                    s_axi_rlast,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int ADDR_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int INDEX_BITS     = $clog2(MEM_DEPTH);

    // Index math stays at full address width so addresses above the array
    // never wrap onto low words.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> ADDR_SHIFT;
    endfunction

    function automatic logic beat_in_range(input logic below, input logic [ADDR_WIDTH-1:0] idx);
        return !below && (idx < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    // Reset is asserted asynchronously but released through two flops; the
    // ready outputs stay low until the release has propagated.
    logic [1:0] rst_sync;
    logic       active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign active = rst_sync[1];

    // ------------------------------------------------------------------ write
    w_state_e                w_state, w_state_next;
    logic [ID_WIDTH-1:0]     w_id;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_below;
    logic [8:0]              w_count;
    logic                    w_dec, w_slv;
    logic                    aw_hs, w_hs, w_beat_ok, w_final;
    logic                    mem_wr_en;

    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign w_beat_ok = beat_in_range(w_below, w_idx);
    assign w_final   = (w_count == 9'd1);
    assign mem_wr_en = w_hs && w_beat_ok;

    // Write engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write engine next state and channel handshake outputs. The B response
    // reports decode errors ahead of wlast protocol errors.
    always_comb begin
        w_state_next  = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = active;
                if (s_axi_awvalid && active) begin
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_final) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = w_dec ? RESP_DECERR : (w_slv ? RESP_SLVERR : RESP_OKAY);
                if (s_axi_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latch the burst on AW, then walk the index
    // and count down per beat while accumulating error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_below <= 1'b0;
            w_count <= '0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_idx   <= word_index(s_axi_awaddr);
            w_below <= (s_axi_awaddr < BASE_ADDR);
            w_count <= {1'b0, s_axi_awlen} + 9'd1;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else if (w_hs) begin
            if (!w_beat_ok) begin
                w_dec <= 1'b1;
            end
            if (s_axi_wlast != w_final) begin
                w_slv <= 1'b1;
            end
            w_idx   <= w_idx + 1'b1;
            w_count <= w_count - 9'd1;
        end
    end

    assign s_axi_bid = w_id;

    // ------------------------------------------------------------------- read
    r_state_e                r_state, r_state_next;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic                    r_below;
    logic [7:0]              r_remaining;
    logic                    r_ok;
    logic                    r_last;
    logic                    ar_hs, r_hs, r_advance;
    logic [ADDR_WIDTH-1:0]   ar_idx;
    logic                    ar_below;
    logic                    mem_rd_en;
    logic [INDEX_BITS-1:0]   mem_rd_idx;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign r_hs      = s_axi_rvalid && s_axi_rready;
    assign r_advance = r_hs && !r_last;
    assign ar_idx    = word_index(s_axi_araddr);
    assign ar_below  = (s_axi_araddr < BASE_ADDR);

    // Read engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Read engine next state and handshake outputs. rvalid is purely the
    // state, so it rises the cycle after AR and drops after the last beat.
    always_comb begin
        r_state_next  = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = active;
                if (s_axi_arvalid && active) begin
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && r_last) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // The array read register is loaded only on AR or on a non-final R
    // handshake, so the presented word holds still while the master stalls.
    always_comb begin
        mem_rd_en  = ar_hs || r_advance;
        mem_rd_idx = ar_hs ? ar_idx[INDEX_BITS-1:0] : r_idx[INDEX_BITS-1:0];
    end

    // Read burst bookkeeping: r_idx always points at the next beat to load,
    // r_ok/r_last describe the beat currently on the R channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id        <= '0;
            r_idx       <= '0;
            r_below     <= 1'b0;
            r_remaining <= '0;
            r_ok        <= 1'b0;
            r_last      <= 1'b0;
        end else if (ar_hs) begin
            r_id        <= s_axi_arid;
            r_idx       <= ar_idx + 1'b1;
            r_below     <= ar_below;
            r_remaining <= s_axi_arlen;
            r_ok        <= beat_in_range(ar_below, ar_idx);
            r_last      <= (s_axi_arlen == 8'd0);
        end else if (r_advance) begin
            r_idx       <= r_idx + 1'b1;
            r_remaining <= r_remaining - 8'd1;
            r_ok        <= beat_in_range(r_below, r_idx);
            r_last      <= (r_remaining == 8'd1);
        end else if (r_hs) begin
            r_ok   <= 1'b0;
            r_last <= 1'b0;
        end
    end

    assign s_axi_rdata = r_ok ? mem_rd_data : '0;
    assign s_axi_rresp = (s_axi_rvalid && !r_ok) ? RESP_DECERR : RESP_OKAY;
    assign s_axi_rlast = r_last;
    assign s_axi_rid   = r_id;

    vortex_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_idx  (w_idx[INDEX_BITS-1:0]),
        .wr_data (s_axi_wdata),
        .wr_strb (s_axi_wstrb),
        .rd_en   (mem_rd_en),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_rd_data)
    );

endmodule

// File: tb/tb_vortex_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_vortex_axi_mem_responder
// Directed bench for the AXI memory responder using default parameters
// (512-bit words, 1024 words, base address 0).
// -----------------------------------------------------------------------------
module tb_vortex_axi_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_axi_awvalid, s_axi_awready;
    logic [63:0]  s_axi_awaddr;
    logic [31:0]  s_axi_awid;
    logic [7:0]   s_axi_awlen;
    logic         s_axi_wvalid, s_axi_wready;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_bvalid, s_axi_bready;
    logic [31:0]  s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_arvalid, s_axi_arready;
    logic [63:0]  s_axi_araddr;
    logic [31:0]  s_axi_arid;
    logic [7:0]   s_axi_arlen;
    logic         s_axi_rvalid, s_axi_rready;
    logic [511:0] s_axi_rdata;
    logic         s_axi_rlast;
    logic [31:0]  s_axi_rid;
    logic [1:0]   s_axi_rresp;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [63:0]  ALL_STRB = '1;
    localparam logic [511:0] PAT_A5   = {64{8'hA5}};
    localparam logic [511:0] PAT_77   = {64{8'h77}};
    localparam logic [511:0] WORD1    = {{63{8'hA5}}, 8'h02};

    vortex_axi_mem_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rresp   (s_axi_rresp)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1ns after
    // the rising edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sendAw(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] id);
        int n = 0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id;
        while (!s_axi_awready && n < 50) begin applyStimulus(1); n++; end
        checkOutput("aw_ready_seen", 512'(s_axi_awready), 512'(1));
        applyStimulus(1);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [511:0] data, input logic [63:0] strb, input logic last);
        int n = 0;
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
        while (!s_axi_wready && n < 50) begin applyStimulus(1); n++; end
        checkOutput("w_ready_seen", 512'(s_axi_wready), 512'(1));
        applyStimulus(1);
        s_axi_wvalid = 1'b0;
    endtask

    task automatic waitB(input logic [31:0] id, input logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 50) begin applyStimulus(1); n++; end
        checkOutput("b_valid_seen", 512'(s_axi_bvalid), 512'(1));
        checkOutput("bid", 512'(s_axi_bid), 512'(id));
        checkOutput("bresp", 512'(s_axi_bresp), 512'(resp));
        applyStimulus(1);
        s_axi_bready = 1'b0;
    endtask

    task automatic sendAr(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] id);
        int n = 0;
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id;
        while (!s_axi_arready && n < 50) begin applyStimulus(1); n++; end
        checkOutput("ar_ready_seen", 512'(s_axi_arready), 512'(1));
        applyStimulus(1);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic recvBeat(input logic [511:0] data, input logic [1:0] resp,
                            input logic last, input logic [31:0] id);
        int n = 0;
        while (!s_axi_rvalid && n < 50) begin applyStimulus(1); n++; end
        checkOutput("r_valid_seen", 512'(s_axi_rvalid), 512'(1));
        checkOutput("rdata", s_axi_rdata, data);
        checkOutput("rresp", 512'(s_axi_rresp), 512'(resp));
        checkOutput("rlast", 512'(s_axi_rlast), 512'(last));
        checkOutput("rid", 512'(s_axi_rid), 512'(id));
        s_axi_rready = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
        s_axi_wvalid = 0;  s_axi_wdata = '0;  s_axi_wstrb = '0; s_axi_wlast = 0;
        s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
        s_axi_rready = 0;

        // Reset state
        applyStimulus(3);
        checkOutput("rst_awready", 512'(s_axi_awready), 512'(0));
        checkOutput("rst_arready", 512'(s_axi_arready), 512'(0));
        checkOutput("rst_bvalid", 512'(s_axi_bvalid), 512'(0));
        checkOutput("rst_rvalid", 512'(s_axi_rvalid), 512'(0));
        checkOutput("rst_rdata", s_axi_rdata, 512'(0));
        checkOutput("rst_rid", 512'(s_axi_rid), 512'(0));
        rst_n = 1'b1;
        applyStimulus(3);
        checkOutput("idle_awready", 512'(s_axi_awready), 512'(1));
        checkOutput("idle_arready", 512'(s_axi_arready), 512'(1));

        // Single write then read at 0x40
        $display("[TB] single write/read");
        sendAw(64'h40, 8'd0, 32'd5);
        sendW(PAT_A5, ALL_STRB, 1'b1);
        waitB(32'd5, 2'b00);
        sendAr(64'h40, 8'd0, 32'd7);
        checkOutput("r_latency_1", 512'(s_axi_rvalid), 512'(1));
        recvBeat(PAT_A5, 2'b00, 1'b1, 32'd7);
        checkOutput("r_done_single", 512'(s_axi_rvalid), 512'(0));

        // Burst of 4 with a partial strobe on beat 2, read back with a stall
        $display("[TB] strobed burst with backpressure");
        sendAw(64'h0, 8'd3, 32'd1);
        sendW(512'd1, ALL_STRB, 1'b0);
        sendW(512'd2, 64'h1, 1'b0);
        sendW(512'd3, ALL_STRB, 1'b0);
        sendW(512'd4, ALL_STRB, 1'b1);
        waitB(32'd1, 2'b00);
        sendAr(64'h0, 8'd3, 32'd2);
        recvBeat(512'd1, 2'b00, 1'b0, 32'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_rvalid", 512'(s_axi_rvalid), 512'(1));
            checkOutput("stall_rdata", s_axi_rdata, WORD1);
            checkOutput("stall_rlast", 512'(s_axi_rlast), 512'(0));
            applyStimulus(1);
        end
        recvBeat(WORD1, 2'b00, 1'b0, 32'd2);
        recvBeat(512'd3, 2'b00, 1'b0, 32'd2);
        recvBeat(512'd4, 2'b00, 1'b1, 32'd2);
        checkOutput("r_done_burst", 512'(s_axi_rvalid), 512'(0));

        // Out of range write and a read crossing the top of the array
        $display("[TB] out of range");
        sendAw(64'h10000, 8'd0, 32'd4);
        sendW({64{8'hFF}}, ALL_STRB, 1'b1);
        waitB(32'd4, 2'b11);
        sendAw(64'hFFC0, 8'd0, 32'd6);
        sendW(PAT_77, ALL_STRB, 1'b1);
        waitB(32'd6, 2'b00);
        sendAr(64'hFFC0, 8'd1, 32'd8);
        recvBeat(PAT_77, 2'b00, 1'b0, 32'd8);
        recvBeat(512'd0, 2'b11, 1'b1, 32'd8);
        sendAr(64'h0, 8'd0, 32'd9);
        recvBeat(512'd1, 2'b00, 1'b1, 32'd9);

        // Early wlast on a two-beat write
        $display("[TB] wlast error");
        sendAw(64'h80, 8'd1, 32'd10);
        sendW(512'h11, ALL_STRB, 1'b1);
        sendW(512'h22, ALL_STRB, 1'b1);
        waitB(32'd10, 2'b10);
        sendAr(64'h80, 8'd1, 32'd11);
        recvBeat(512'h11, 2'b00, 1'b0, 32'd11);
        recvBeat(512'h22, 2'b00, 1'b1, 32'd11);

        // AW and AR in the same cycle, B held off for five cycles
        $display("[TB] concurrency");
        s_axi_awvalid = 1'b1; s_axi_awaddr = 64'hC0; s_axi_awlen = 8'd0; s_axi_awid = 32'd9;
        s_axi_arvalid = 1'b1; s_axi_araddr = 64'h0;  s_axi_arlen = 8'd0; s_axi_arid = 32'd3;
        checkOutput("conc_awready", 512'(s_axi_awready), 512'(1));
        checkOutput("conc_arready", 512'(s_axi_arready), 512'(1));
        applyStimulus(1);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        checkOutput("conc_rvalid", 512'(s_axi_rvalid), 512'(1));
        checkOutput("conc_rdata", s_axi_rdata, 512'd1);
        checkOutput("conc_rid", 512'(s_axi_rid), 512'(3));
        checkOutput("conc_wready", 512'(s_axi_wready), 512'(1));
        s_axi_rready = 1'b1;
        s_axi_wvalid = 1'b1; s_axi_wdata = 512'h33; s_axi_wstrb = ALL_STRB; s_axi_wlast = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0; s_axi_wvalid = 1'b0;
        checkOutput("conc_read_done", 512'(s_axi_rvalid), 512'(0));
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_bvalid", 512'(s_axi_bvalid), 512'(1));
            checkOutput("bp_bid", 512'(s_axi_bid), 512'(9));
            checkOutput("bp_bresp", 512'(s_axi_bresp), 512'(0));
            checkOutput("bp_awready", 512'(s_axi_awready), 512'(0));
            applyStimulus(1);
        end
        s_axi_bready = 1'b1;
        applyStimulus(1);
        s_axi_bready = 1'b0;
        checkOutput("b_done_bvalid", 512'(s_axi_bvalid), 512'(0));
        checkOutput("b_done_awready", 512'(s_axi_awready), 512'(1));
        sendAr(64'hC0, 8'd0, 32'd12);
        recvBeat(512'h33, 2'b00, 1'b1, 32'd12);

        // Reset during beat 2 of an eight-beat read
        $display("[TB] reset mid-burst");
        sendAr(64'h0, 8'd7, 32'd13);
        recvBeat(512'd1, 2'b00, 1'b0, 32'd13);
        recvBeat(WORD1, 2'b00, 1'b0, 32'd13);
        checkOutput("pre_rst_rvalid", 512'(s_axi_rvalid), 512'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", 512'(s_axi_rvalid), 512'(0));
        checkOutput("mid_rst_rdata", s_axi_rdata, 512'(0));
        checkOutput("mid_rst_rid", 512'(s_axi_rid), 512'(0));
        checkOutput("mid_rst_arready", 512'(s_axi_arready), 512'(0));
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(3);
        checkOutput("post_rst_arready", 512'(s_axi_arready), 512'(1));
        checkOutput("post_rst_rvalid", 512'(s_axi_rvalid), 512'(0));
        sendAr(64'h40, 8'd0, 32'd14);
        recvBeat(WORD1, 2'b00, 1'b1, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
